// File: rtl/dac_sched_pkg.sv
// rtl/dac_sched_pkg.sv - FSM encoding and timing defaults shared by the DAC sample scheduler
package dac_sched_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_START   = 2'd1;
   localparam logic [1:0] ST_WAIT_LO = 2'd2;
   localparam logic [1:0] ST_WAIT_HI = 2'd3;

   // MIN_DIV covers one full two-word transfer of the DAC driver
   localparam int MIN_DIV_DEF = 400;
   localparam int CSN_TO_DEF  = 8;

endpackage

// File: rtl/dac_rate_timer.sv
// rtl/dac_rate_timer.sv - sample-period divider with clamped period latch and tick output
module dac_rate_timer
   import dac_sched_pkg::*;
#(
   parameter int DIV_W   = 16,
   parameter int MIN_DIV = MIN_DIV_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   localparam logic [DIV_W-1:0] MIN_P = DIV_W'(MIN_DIV);

   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] period;
   logic [DIV_W-1:0] div_eff;
   logic [DIV_W-1:0] period_eff;
   logic             en_q;
   logic             rise;

   assign div_eff    = (div < MIN_P) ? MIN_P : div;
   assign rise       = enable & ~en_q;
   // On the first enabled cycle the latched period is stale, so use div directly
   assign period_eff = rise ? div_eff : period;
   assign tick       = enable & (count == period_eff - DIV_W'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count  <= '0;
         period <= '0;
         en_q   <= 1'b0;
      end else begin
         en_q <= enable;
         if (rise || tick) begin
            period <= div_eff;
         end
         if (!enable || tick) begin
            count <= '0;
         end else begin
            count <= count + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/dac_sample_scheduler.sv
// rtl/dac_sample_scheduler.sv - paces a two-channel DAC driver at a programmable sample rate
// Define DAC_SCHED_STATS_EN to add saturating overrun/underrun event counters.
module dac_sample_scheduler
   import dac_sched_pkg::*;
#(
   parameter int DATA_W  = 12,
   parameter int DIV_W   = 16,
   parameter int MIN_DIV = MIN_DIV_DEF,
   parameter int CSN_TO  = CSN_TO_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic [DIV_W-1:0]  div,
   input  logic [DATA_W-1:0] ch1_data,
   input  logic              ch1_valid,
   output logic              ch1_ready,
   input  logic [DATA_W-1:0] ch2_data,
   input  logic              ch2_valid,
   output logic              ch2_ready,
   input  logic              dac_csn,
   output logic [DATA_W-1:0] dac_din1,
   output logic [DATA_W-1:0] dac_din2,
   output logic              dac_start,
   output logic              busy,
   output logic              overrun,
   output logic [1:0]        underrun,
   output logic              fault,
`ifdef DAC_SCHED_STATS_EN
   output logic [15:0]       ovr_cnt,
   output logic [15:0]       udr_cnt,
`endif
   input  logic              clr_flags
);

   localparam int              TO_W    = $clog2(CSN_TO + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(CSN_TO - 1);

   logic              tick;
   logic [1:0]        state;
   logic [TO_W-1:0]   to_cnt;
   logic              full1;
   logic              full2;
   logic [DATA_W-1:0] hold1;
   logic [DATA_W-1:0] hold2;
   logic              load1;
   logic              load2;
   logic              accept;
   logic              ovr_evt;
   logic              csn_timeout;
   logic [1:0]        udr_evt;

   dac_rate_timer #(
      .DIV_W   (DIV_W),
      .MIN_DIV (MIN_DIV)
   ) u_timer (
      .clk    (clk),
      .rstn   (rstn),
      .enable (enable),
      .div    (div),
      .tick   (tick)
   );

   assign ch1_ready   = ~full1;
   assign ch2_ready   = ~full2;
   assign load1       = ch1_valid & ch1_ready;
   assign load2       = ch2_valid & ch2_ready;
   assign accept      = tick & (state == ST_IDLE);
   assign ovr_evt     = tick & (state != ST_IDLE);
   assign csn_timeout = (state == ST_WAIT_LO) & dac_csn & (to_cnt == TO_LAST);
   assign udr_evt     = {accept & ~full2, accept & ~full1};
   assign dac_start   = (state == ST_START);
   assign busy        = (state != ST_IDLE);

   // One-deep holding registers; a same-cycle load refills after the old value is consumed
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full1 <= 1'b0;
         full2 <= 1'b0;
         hold1 <= '0;
         hold2 <= '0;
      end else begin
         full1 <= load1 | (full1 & ~accept);
         full2 <= load2 | (full2 & ~accept);
         if (load1) begin
            hold1 <= ch1_data;
         end
         if (load2) begin
            hold2 <= ch2_data;
         end
      end
   end

   // Empty channels keep their previous DAC word
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dac_din1 <= '0;
         dac_din2 <= '0;
      end else begin
         if (accept && full1) begin
            dac_din1 <= hold1;
         end
         if (accept && full2) begin
            dac_din2 <= hold2;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= ST_IDLE;
         to_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tick) begin
                  state <= ST_START;
               end
            end
            ST_START: begin
               state  <= ST_WAIT_LO;
               to_cnt <= '0;
            end
            ST_WAIT_LO: begin
               if (!dac_csn) begin
                  state <= ST_WAIT_HI;
               end else if (to_cnt == TO_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            ST_WAIT_HI: begin
               if (dac_csn) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Sticky flags: a set event in the same cycle as clr_flags wins
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overrun  <= 1'b0;
         underrun <= 2'b00;
         fault    <= 1'b0;
      end else begin
         overrun  <= ovr_evt | (overrun & ~clr_flags);
         underrun <= udr_evt | (underrun & {2{~clr_flags}});
         fault    <= csn_timeout | (fault & ~clr_flags);
      end
   end

`ifdef DAC_SCHED_STATS_EN
   logic udr_any;

   assign udr_any = |udr_evt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovr_cnt <= '0;
         udr_cnt <= '0;
      end else begin
         if (clr_flags) begin
            ovr_cnt <= {15'd0, ovr_evt};
         end else if (ovr_evt && ovr_cnt != 16'hFFFF) begin
            ovr_cnt <= ovr_cnt + 16'd1;
         end
         if (clr_flags) begin
            udr_cnt <= {15'd0, udr_any};
         end else if (udr_any && udr_cnt != 16'hFFFF) begin
            udr_cnt <= udr_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb/tb_dac_sample_scheduler.sv - self-checking bench for dac_sample_scheduler
module tb_dac_sample_scheduler;

   logic        clk = 1'b0;
   logic        rstn;
   logic        enable;
   logic [15:0] div;
   logic [11:0] ch1_data;
   logic        ch1_valid;
   logic        ch1_ready;
   logic [11:0] ch2_data;
   logic        ch2_valid;
   logic        ch2_ready;
   logic        dac_csn = 1'b1;
   logic [11:0] dac_din1;
   logic [11:0] dac_din2;
   logic        dac_start;
   logic        busy;
   logic        overrun;
   logic [1:0]  underrun;
   logic        fault;
   logic        clr_flags;
`ifdef DAC_SCHED_STATS_EN
   logic [15:0] ovr_cnt;
   logic [15:0] udr_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int csn_low   = 300;
   bit csn_stuck = 1'b0;
   int fall_cd   = 0;
   int low_cd    = 0;

   logic [11:0] m_din1, m_din2, m_hold1, m_hold2;
   bit          m_full1, m_full2;
   logic [1:0]  exp_udr;

   dac_sample_scheduler dut (
      .clk       (clk),
      .rstn      (rstn),
      .enable    (enable),
      .div       (div),
      .ch1_data  (ch1_data),
      .ch1_valid (ch1_valid),
      .ch1_ready (ch1_ready),
      .ch2_data  (ch2_data),
      .ch2_valid (ch2_valid),
      .ch2_ready (ch2_ready),
      .dac_csn   (dac_csn),
      .dac_din1  (dac_din1),
      .dac_din2  (dac_din2),
      .dac_start (dac_start),
      .busy      (busy),
      .overrun   (overrun),
      .underrun  (underrun),
      .fault     (fault),
`ifdef DAC_SCHED_STATS_EN
      .ovr_cnt   (ovr_cnt),
      .udr_cnt   (udr_cnt),
`endif
      .clr_flags (clr_flags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // DAC driver model: csn falls 2 cycles after start and stays low for csn_low cycles
   always @(negedge clk) begin
      if (!rstn) begin
         dac_csn = 1'b1;
         fall_cd = 0;
         low_cd  = 0;
      end else begin
         if (low_cd > 0) begin
            low_cd = low_cd - 1;
            if (low_cd == 0) dac_csn = 1'b1;
         end
         if (fall_cd > 0) begin
            fall_cd = fall_cd - 1;
            if (fall_cd == 0) begin
               dac_csn = 1'b0;
               low_cd  = csn_low;
            end
         end
         if (dac_start && !csn_stuck) fall_cd = 2;
      end
   end

   function automatic logic [11:0] rnd12();
      return 12'($urandom);
   endfunction

   function automatic int clampp(input int d);
      return (d < 400) ? 400 : d;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int target, output int starts);
      starts = 0;
      while (cyc < target) begin
         step();
         if (dac_start) starts++;
      end
   endtask

   task automatic wait_start(input int limit);
      int n = 0;
      do begin
         step();
         n++;
      end while (!dac_start && n < limit);
      checks++;
      if (dac_start !== 1'b1) begin
         errors++;
         $display("FAIL start_timeout: dac_start=%b after %0d cycles, required 1", dac_start, n);
      end
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy && n < limit) begin
         step();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic clear_flags();
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      exp_udr   = 2'b00;
   endtask

   task automatic push(input bit c1, input logic [11:0] d1, input bit c2, input logic [11:0] d2);
      checks++;
      if ({ch1_ready, ch2_ready} !== {~m_full1, ~m_full2}) begin
         errors++;
         $display("FAIL push_ready: ready=%b%b required %b%b", ch1_ready, ch2_ready, ~m_full1, ~m_full2);
      end
      ch1_valid = c1;
      ch1_data  = d1;
      ch2_valid = c2;
      ch2_data  = d2;
      step();
      ch1_valid = 1'b0;
      ch2_valid = 1'b0;
      if (c1) begin m_full1 = 1'b1; m_hold1 = d1; end
      if (c2) begin m_full2 = 1'b1; m_hold2 = d2; end
   endtask

   task automatic model_take();
      if (m_full1) begin m_din1 = m_hold1; m_full1 = 1'b0; end
      else exp_udr[0] = 1'b1;
      if (m_full2) begin m_din2 = m_hold2; m_full2 = 1'b0; end
      else exp_udr[1] = 1'b1;
   endtask

   task automatic model_reset();
      m_din1 = '0; m_din2 = '0; m_hold1 = '0; m_hold2 = '0;
      m_full1 = 1'b0; m_full2 = 1'b0; exp_udr = 2'b00;
   endtask

   task automatic test_reset();
      #50;
      checks++;
      if ({ch1_ready, ch2_ready} !== 2'b11) begin
         errors++;
         $display("FAIL reset_ready: got %b%b required 11", ch1_ready, ch2_ready);
      end
      checks++;
      if ({dac_start, busy, overrun, underrun, fault} !== 6'b0) begin
         errors++;
         $display("FAIL reset_status: got %b required 000000", {dac_start, busy, overrun, underrun, fault});
      end
      checks++;
      if ({dac_din1, dac_din2} !== 24'h0) begin
         errors++;
         $display("FAIL reset_din: got %h required 000000", {dac_din1, dac_din2});
      end
      #50;
      rstn = 1'b1;
      step();
   endtask

   task automatic test_first_sample();
      int c0, cnt;
      bit stable;
      push(1'b1, 12'h800, 1'b1, 12'h800);
      div    = 16'd1000;
      enable = 1'b1;
      c0     = cyc;
      wait_start(1100);
      checks++;
      if (cyc - c0 != 1000) begin
         errors++;
         $display("FAIL first_latency: got %0d required 1000", cyc - c0);
      end
      model_take();
      checks++;
      if ({dac_din1, dac_din2} !== {m_din1, m_din2}) begin
         errors++;
         $display("FAIL first_din: got %h required %h", {dac_din1, dac_din2}, {m_din1, m_din2});
      end
      checks++;
      if ({busy, ch1_ready, ch2_ready, underrun} !== 5'b11100) begin
         errors++;
         $display("FAIL first_status: got %b required 11100", {busy, ch1_ready, ch2_ready, underrun});
      end
      cnt    = 0;
      stable = 1'b1;
      while (busy && cnt < 400) begin
         if ({dac_din1, dac_din2} !== {m_din1, m_din2}) stable = 1'b0;
         step();
         cnt++;
      end
      // csn low occupies cycles 2..301 after start; IDLE is seen one cycle after the rise
      checks++;
      if (cnt != 303 || !stable || dac_csn !== 1'b1) begin
         errors++;
         $display("FAIL first_busy: busy_len=%0d stable=%0b csn=%b required 303 1 1", cnt, stable, dac_csn);
      end
      enable = 1'b0;
      step();
   endtask

   task automatic test_clamp();
      int s;
      div = 16'd10;
      push(1'b1, rnd12(), 1'b1, rnd12());
      enable = 1'b1;
      s = cyc;
      for (int i = 0; i < 3; i++) begin
         wait_start(500);
         checks++;
         if (cyc - s != 400) begin
            errors++;
            $display("FAIL clamp_spacing[%0d]: got %0d required 400", i, cyc - s);
         end
         s = cyc;
         model_take();
         checks++;
         if ({dac_din1, dac_din2} !== {m_din1, m_din2}) begin
            errors++;
            $display("FAIL clamp_din[%0d]: got %h required %h", i, {dac_din1, dac_din2}, {m_din1, m_din2});
         end
         if (i < 2) push(1'b1, rnd12(), 1'b1, rnd12());
      end
      checks++;
      if ({overrun, underrun} !== 3'b000) begin
         errors++;
         $display("FAIL clamp_flags: got %b required 000", {overrun, underrun});
      end
      enable = 1'b0;
      wait_idle(500);
   endtask

   task automatic test_overrun();
      int s, ns, n2;
      clear_flags();
      csn_low = 500;
      div     = 16'd400;
      push(1'b1, rnd12(), 1'b1, rnd12());
      enable = 1'b1;
      s = cyc;
      wait_start(500);
      checks++;
      if (cyc - s != 400) begin
         errors++;
         $display("FAIL ovr_latency: got %0d required 400", cyc - s);
      end
      s = cyc;
      model_take();
      push(1'b1, rnd12(), 1'b1, rnd12());
      run_to(s + 399, ns);
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_before: got %b required 0", overrun);
      end
      clr_flags = 1'b1;
      run_to(s + 400, n2);
      clr_flags = 1'b0;
      ns += n2;
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_set_wins: got %b required 1", overrun);
      end
      checks++;
      if ({ch1_ready, ch2_ready} !== {~m_full1, ~m_full2}) begin
         errors++;
         $display("FAIL ovr_buffers: ready=%b%b required %b%b", ch1_ready, ch2_ready, ~m_full1, ~m_full2);
      end
      run_to(s + 799, n2);
      ns += n2;
      step();
      checks++;
      if (ns != 0 || dac_start !== 1'b1) begin
         errors++;
         $display("FAIL ovr_starts: extra=%0d start_at_800=%b required 0 1", ns, dac_start);
      end
      model_take();
      checks++;
      if ({dac_din1, dac_din2} !== {m_din1, m_din2}) begin
         errors++;
         $display("FAIL ovr_din: got %h required %h", {dac_din1, dac_din2}, {m_din1, m_din2});
      end
      clear_flags();
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_clear: got %b required 0", overrun);
      end
      enable = 1'b0;
      wait_idle(700);
      csn_low = 300;
   endtask

   task automatic test_underrun();
      clear_flags();
      div = 16'd400;
      push(1'b1, 12'hAAA, 1'b0, 12'h000);
      enable = 1'b1;
      wait_start(500);
      model_take();
      checks++;
      if ({dac_din1, dac_din2, underrun} !== {m_din1, m_din2, exp_udr}) begin
         errors++;
         $display("FAIL udr_ch2: din=%h udr=%b required din=%h udr=%b",
                  {dac_din1, dac_din2}, underrun, {m_din1, m_din2}, exp_udr);
      end
      enable = 1'b0;
      wait_idle(500);
   endtask

   task automatic test_fault();
      int s, ns;
      clear_flags();
      csn_stuck = 1'b1;
      div = 16'd400;
      push(1'b1, rnd12(), 1'b1, rnd12());
      enable = 1'b1;
      wait_start(500);
      s = cyc;
      model_take();
      run_to(s + 8, ns);
      checks++;
      if ({fault, busy} !== 2'b01) begin
         errors++;
         $display("FAIL fault_before: fault,busy=%b required 01", {fault, busy});
      end
      step();
      checks++;
      if ({fault, busy} !== 2'b10) begin
         errors++;
         $display("FAIL fault_set: fault,busy=%b required 10", {fault, busy});
      end
      csn_stuck = 1'b0;
      push(1'b1, rnd12(), 1'b1, rnd12());
      wait_start(500);
      model_take();
      checks++;
      if (cyc - s != 400 || {dac_din1, dac_din2} !== {m_din1, m_din2} || fault !== 1'b1) begin
         errors++;
         $display("FAIL fault_recover: spacing=%0d din=%h fault=%b required 400 %h 1",
                  cyc - s, {dac_din1, dac_din2}, fault, {m_din1, m_din2});
      end
      enable = 1'b0;
      wait_idle(500);
   endtask

   task automatic test_random();
      int s, p;
      clear_flags();
      div = 16'($urandom_range(0, 700));
      p   = clampp(int'(div));
      push(1'($urandom_range(0, 1)), rnd12(), 1'($urandom_range(0, 1)), rnd12());
      enable = 1'b1;
      s = cyc;
      for (int i = 0; i < 6; i++) begin
         wait_start(800);
         checks++;
         if (cyc - s != p) begin
            errors++;
            $display("FAIL rnd_spacing[%0d]: got %0d required %0d", i, cyc - s, p);
         end
         model_take();
         checks++;
         if ({dac_din1, dac_din2, underrun} !== {m_din1, m_din2, exp_udr}) begin
            errors++;
            $display("FAIL rnd_sample[%0d]: din=%h udr=%b required din=%h udr=%b",
                     i, {dac_din1, dac_din2}, underrun, {m_din1, m_din2}, exp_udr);
         end
         // The period after each tick is the div present at that tick
         p = clampp(int'(div));
         s = cyc;
         push(1'($urandom_range(0, 1)), rnd12(), 1'($urandom_range(0, 1)), rnd12());
         div = 16'($urandom_range(0, 700));
      end
      enable = 1'b0;
      wait_idle(500);
   endtask

   task automatic test_reset_wait_hi();
      int s, r, ns;
      clear_flags();
      div = 16'd400;
      push(1'b1, rnd12(), 1'b0, 12'h000);
      enable = 1'b1;
      wait_start(500);
      s = cyc;
      model_take();
      push(1'b1, rnd12(), 1'b1, rnd12());
      run_to(s + 10, ns);
      checks++;
      if ({busy, dac_csn, underrun, ch1_ready} !== 5'b10100) begin
         errors++;
         $display("FAIL rst_pre: busy,csn,udr,ready1=%b required 10100", {busy, dac_csn, underrun, ch1_ready});
      end
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({busy, dac_start, overrun, underrun, fault, ch1_ready, ch2_ready} !== 7'b0000011 ||
          {dac_din1, dac_din2} !== 24'h0) begin
         errors++;
         $display("FAIL rst_async: status=%b din=%h required 0000011 000000",
                  {busy, dac_start, overrun, underrun, fault, ch1_ready, ch2_ready}, {dac_din1, dac_din2});
      end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      r = cyc;
      run_to(r + 399, ns);
      step();
      checks++;
      if (ns != 0 || dac_start !== 1'b1) begin
         errors++;
         $display("FAIL rst_restart: early_starts=%0d start_at_400=%b required 0 1", ns, dac_start);
      end
      model_take();
      checks++;
      if ({dac_din1, dac_din2, underrun} !== {m_din1, m_din2, exp_udr}) begin
         errors++;
         $display("FAIL rst_sample: din=%h udr=%b required din=%h udr=%b",
                  {dac_din1, dac_din2}, underrun, {m_din1, m_din2}, exp_udr);
      end
      enable = 1'b0;
      wait_idle(500);
   endtask

   initial begin
      rstn      = 1'b0;
      enable    = 1'b0;
      div       = 16'd0;
      ch1_data  = '0;
      ch1_valid = 1'b0;
      ch2_data  = '0;
      ch2_valid = 1'b0;
      clr_flags = 1'b0;
      model_reset();
      test_reset();
      test_first_sample();
      test_clamp();
      test_overrun();
      test_underrun();
      test_fault();
      test_random();
      test_reset_wait_hi();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
